// File: rtl/comparador_serial.sv
`default_nettype none
// ============================================================================
// Module      : comparador_serial
// Description : Multi-cycle magnitude comparator. Operands are latched on a
//               start request and examined one BITS_POR_CICLO-wide chunk per
//               clock, most-significant chunk first, stopping at the first
//               chunk that differs. Signed mode flips each operand's MSB so
//               that a plain unsigned chunk compare orders two's-complement
//               values correctly.
// Ports       : clk      - system clock, rising edge
//               reset    - synchronous, active-high reset
//               inicio   - start request, sampled only while idle
//               sinal    - 0 = unsigned, 1 = two's-complement signed
//               A, B     - operands, sampled with inicio
//               ocupado  - comparison in progress
//               pronto   - one-cycle pulse: result flags are valid
//               Igual    - A == B
//               Maior    - A >  B
//               Menor    - A <  B
// Revision    : 1.0 - initial release
// ============================================================================
module comparador_serial #(
    parameter int WIDTH          = 8,
    parameter int BITS_POR_CICLO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic             sinal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ocupado,
    output logic             pronto,
    output logic             Igual,
    output logic             Maior,
    output logic             Menor
);

    localparam int NCHUNK = WIDTH / BITS_POR_CICLO;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [0:0] {
        OCIOSO  = 1'b0,
        COMPARA = 1'b1
    } estado_t;

    estado_t            r_estado;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Chunks remaining after the current one; zero means the LSB chunk.
    logic [PTR_W-1:0]   r_ptr;

    logic [BITS_POR_CICLO-1:0] w_chunk_a;
    logic [BITS_POR_CICLO-1:0] w_chunk_b;
    logic                      w_difere;
    logic                      w_maior;

    // The latched operands shift left each cycle, so the chunk under
    // examination always sits in the top bits.
    assign w_chunk_a = r_a[WIDTH-1 -: BITS_POR_CICLO];
    assign w_chunk_b = r_b[WIDTH-1 -: BITS_POR_CICLO];
    assign w_difere  = (w_chunk_a != w_chunk_b);
    assign w_maior   = (w_chunk_a >  w_chunk_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_a      <= '0;
            r_b      <= '0;
            r_ptr    <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            Igual    <= 1'b0;
            Maior    <= 1'b0;
            Menor    <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (inicio) begin
                        // Offset-binary mapping: flipping the sign bit makes
                        // signed order equal unsigned order.
                        r_a      <= {A[WIDTH-1] ^ sinal, A[WIDTH-2:0]};
                        r_b      <= {B[WIDTH-1] ^ sinal, B[WIDTH-2:0]};
                        r_ptr    <= PTR_W'(NCHUNK - 1);
                        Igual    <= 1'b0;
                        Maior    <= 1'b0;
                        Menor    <= 1'b0;
                        ocupado  <= 1'b1;
                        r_estado <= COMPARA;
                    end
                end
                COMPARA: begin
                    if (w_difere) begin
                        Maior    <= w_maior;
                        Menor    <= ~w_maior;
                        pronto   <= 1'b1;
                        ocupado  <= 1'b0;
                        r_estado <= OCIOSO;
                    end else if (r_ptr == '0) begin
                        Igual    <= 1'b1;
                        pronto   <= 1'b1;
                        ocupado  <= 1'b0;
                        r_estado <= OCIOSO;
                    end else begin
                        r_a   <= r_a << BITS_POR_CICLO;
                        r_b   <= r_b << BITS_POR_CICLO;
                        r_ptr <= r_ptr - PTR_W'(1);
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                    ocupado  <= 1'b0;
                    pronto   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comparador_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparador_serial
// Description : Scoreboard bench for comparador_serial. Two instances (one and
//               four bits per cycle) share the stimulus; each accepted request
//               pushes its expected flags and latency into a per-instance
//               queue, and a monitor pops and compares on every pronto pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparador_serial;

    typedef struct {
        logic [2:0] f;     // {Igual, Maior, Menor}
        int         k;     // edges from acceptance to decision
        int         acc;   // cycle count right after the accepting edge
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       sinal = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;

    logic ocup1, pron1, ig1, ma1, me1;
    logic ocup4, pron4, ig4, ma4, me4;
    logic [2:0] f1, f4;

    assign f1 = {ig1, ma1, me1};
    assign f4 = {ig4, ma4, me4};

    int   cyc  = 0;
    int   ncmp = 0;
    int   nerr = 0;
    exp_t q1[$];
    exp_t q4[$];

    comparador_serial #(.WIDTH(8), .BITS_POR_CICLO(1)) dut1 (
        .clk(clk), .reset(reset), .inicio(inicio), .sinal(sinal),
        .A(A), .B(B), .ocupado(ocup1), .pronto(pron1),
        .Igual(ig1), .Maior(ma1), .Menor(me1)
    );

    comparador_serial #(.WIDTH(8), .BITS_POR_CICLO(4)) dut4 (
        .clk(clk), .reset(reset), .inicio(inicio), .sinal(sinal),
        .A(A), .B(B), .ocupado(ocup4), .pronto(pron4),
        .Igual(ig4), .Maior(ma4), .Menor(me4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: every pronto pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (pron1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("bpc1_unexpected_pronto", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("bpc1_flags", {29'd0, f1}, {29'd0, e.f});
                chk("bpc1_latency", cyc - e.acc, e.k);
                chk("bpc1_ocupado_at_pronto", {31'd0, ocup1}, 32'd0);
            end
        end
        if (pron4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("bpc4_unexpected_pronto", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("bpc4_flags", {29'd0, f4}, {29'd0, e.f});
                chk("bpc4_latency", cyc - e.acc, e.k);
                chk("bpc4_ocupado_at_pronto", {31'd0, ocup4}, 32'd0);
            end
        end
    end

    // Called at posedge+1; presents a request and returns just after acceptance.
    task automatic issue(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] f, input int k1, input int k4);
        sinal  = s;
        A      = a;
        B      = b;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        q1.push_back('{f, k1, cyc});
        q4.push_back('{f, k4, cyc});
        chk("ocupado_after_accept", {30'd0, ocup1, ocup4}, 32'd3);
    endtask

    // Waits (bounded) for all outstanding results, then checks the flags hold.
    task automatic drain(input logic [2:0] f);
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q1.size() + q4.size(), 32'd0);
        q1.delete();
        q4.delete();
        repeat (2) @(negedge clk);
        chk("bpc1_flags_hold", {29'd0, f1}, {29'd0, f});
        chk("bpc4_flags_hold", {29'd0, f4}, {29'd0, f});
        @(posedge clk);
        #1;
    endtask

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {22'd0, ocup1, pron1, f1, ocup4, pron4, f4}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Equal operands: full scan in both configurations.
        issue(1'b0, 8'h5A, 8'h5A, EQ, 8, 2); drain(EQ);
        // MSB decides; signedness flips the answer.
        issue(1'b0, 8'h80, 8'h7F, GT, 1, 1); drain(GT);
        issue(1'b1, 8'h80, 8'h7F, LT, 1, 1); drain(LT);

        // Operand/mode changes mid-operation must be ignored.
        issue(1'b0, 8'h12, 8'h13, LT, 8, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        A = 8'hFF;
        B = 8'h00;
        sinal = 1'b1;
        drain(LT);

        issue(1'b1, 8'h3D, 8'h3C, GT, 8, 2); drain(GT);
        issue(1'b1, 8'hF0, 8'h10, LT, 1, 1); drain(LT);
        issue(1'b1, 8'hFF, 8'hFE, GT, 8, 2); drain(GT);
        issue(1'b0, 8'h0F, 8'h1F, LT, 4, 1); drain(LT);
        issue(1'b1, 8'h7F, 8'h80, GT, 1, 1); drain(GT);

        // Back-to-back: inicio held high is taken again in the pronto cycle.
        sinal  = 1'b0;
        A      = 8'h80;
        B      = 8'h7F;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        q1.push_back('{GT, 1, cyc});
        q4.push_back('{GT, 1, cyc});
        sinal = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        inicio = 1'b0;
        q1.push_back('{LT, 1, cyc});
        q4.push_back('{LT, 1, cyc});
        chk("b2b_reaccept", {30'd0, ocup1, ocup4}, 32'd3);
        drain(LT);

        // Reset at the third edge after acceptance aborts the 1-bit instance;
        // the 4-bit instance has already finished at edge 2.
        sinal  = 1'b0;
        A      = 8'h00;
        B      = 8'h00;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        q4.push_back('{EQ, 2, cyc});
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_state", {22'd0, ocup1, pron1, f1, ocup4, pron4, f4}, 32'd0);
        chk("abort_queue4", q4.size(), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_pronto", {30'd0, pron1, ocup1}, 32'd0);

        issue(1'b0, 8'h00, 8'h00, EQ, 8, 2); drain(EQ);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
